game_state_controller: RTL and testbench
========================================

# game_state_controller

Game-rules engine for the HDMI/VGA dodge game, sitting beside the obstacle and player controllers in `top`. It owns the play/over state machine and a frame-based obstacle spawn timer with pseudo-random start column. It produces `obstacle_trigger` and `obstacle_start_x` for the obstacle controller and consumes player/obstacle positions for collision detection and scoring. Its score and difficulty outputs drive the render path and the obstacle speed.

## Interface
Parameters:
- `SPRITE_W`, 32: player and obstacle width (px)
- `SPRITE_H`, 32: player and obstacle height (px)
- `SPAWN_FRAMES`, 90: initial spawn period (frames)
- `MIN_SPAWN_FRAMES`, 20: spawn-period floor
- `SPAWN_DEC`, 8: period reduction per 10 points
- `X_RANGE`, 608: start-x range, giving `0..X_RANGE-1`

Ports (one clock; reset is asynchronous and active-high):
- `CLOCK_50` in 1: system clock
- `reset` in 1: async active-high reset
- `vsync` in 1: `VGA_VS`, active-low, same clock domain
- `start_n` in 1: KEY button, active-low, asynchronous
- `player_x`, `player_y` in 10 each: player top-left
- `obstacle_x`, `obstacle_y` in 10 each: obstacle top-left
- `obstacle_active` in 1: obstacle on screen
- `obstacle_trigger` out 1: one-cycle spawn pulse
- `obstacle_start_x` out 10: spawn column, valid when trigger is high
- `obstacle_step` out 3: obstacle pixels per frame
- `playing` out 1: state is PLAY
- `game_over` out 1: state is OVER
- `score` out 7: current score, 0..99
- `max_score` out 7: best score since reset

## Operation
- `start_n` is synchronised by 2 flops; a press is the registered falling edge and yields one pulse per press.
- Frame tick: `tick = vsync_q & ~vsync`, i.e. falling edge of `vsync`.
- FSM states: IDLE, PLAY, OVER. Reset enters IDLE.
  - IDLE → PLAY on a press.
  - PLAY → OVER on a collision.
  - OVER → PLAY on a press.
- Every entry to PLAY performs:
  - clear `score` and the spawn timer;
  - period = `SPAWN_FRAMES`;
  - `obstacle_step` = 1.
- Spawn timer (PLAY only) increments on each tick. When it reaches period−1 on a tick:
  - the timer returns to 0;
  - `obstacle_trigger` pulses;
  - `obstacle_start_x` is latched from the LFSR.
- LFSR:
  - 10-bit Fibonacci, taps x^10+x^7+1, seed 10'h001; it never reaches zero.
  - It advances every clock in all states.
  - Start-x = `lfsr >= X_RANGE ? lfsr - X_RANGE : lfsr`, giving 0..607.
- Collision is evaluated on tick, in PLAY, with `obstacle_active` high. It is AABB with 11-bit operands:
  - `px < ox+SPRITE_W`
  - `ox < px+SPRITE_W`
  - `py < oy+SPRITE_H`
  - `oy < py+SPRITE_H`
- Pass = falling edge of registered `obstacle_active` in PLAY. A pass increments `score`, which saturates at 99.
- Difficulty: each time `score` reaches a multiple of 10 (10, 20, …):
  - period −= `SPAWN_DEC`, floored at `MIN_SPAWN_FRAMES`;
  - `obstacle_step` +1, saturating at 7.
- On entry to OVER: `max_score` = max(`max_score`, `score`). `score` is held in OVER.
- Simultaneous events:
  - Collision and pass in the same cycle: collision wins and no point is scored.
  - Collision and spawn on the same tick: the trigger is suppressed.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE;
  - `playing`, `game_over`, `obstacle_trigger` = 0;
  - `score`, `max_score`, `obstacle_start_x` = 0;
  - `obstacle_step` = 1;
  - LFSR = 10'h001; spawn timer = 0; period = `SPAWN_FRAMES`.
- Press: `start_n` low → `playing` high after 3 edges (2 sync flops + edge register → state).
- Tick cycle → `obstacle_trigger`/`game_over` high on the next edge. The trigger is high for exactly 1 cycle.
- `obstacle_active` fall → `score` updates 2 edges later (registered edge detect + score register).
- Reset asserted mid-game: all state returns to reset values immediately (async). Deassertion is synchronous to `CLOCK_50`.

## Structure
- Package `game_pkg`:
  - state enum (IDLE/PLAY/OVER);
  - `SCREEN_W`=640, `SCREEN_H`=480;
  - sprite size constants;
  - `SCORE_MAX`=99.
- Sub-module `lfsr10`: `CLOCK_50`, `reset`, `q[9:0]`, free-running. Everything else lives in one module.

## Test plan
- Reset, then press `start_n` → `playing`=1 at 3 edges, `score`=0, `obstacle_step`=1, no trigger before 90 ticks.
- Playing, 90 vsync falls → exactly one 1-cycle `obstacle_trigger`; `obstacle_start_x` ≤ 607; a repeated run from reset gives an identical sequence.
- Player (100,400), obstacle (120,380), active, tick → `game_over`=1, trigger suppressed. Obstacle (140,380) → no collision.
- 10 `obstacle_active` falls → `score`=10, period 82, step 2. 100 falls → `score`=99 (saturated), period floored at 20, step 7.
- Score 12 → collision → `max_score`=12; press → `score`=0, `max_score` 12 kept; next game scores 5 then collides → `max_score` stays 12.
- Pass and collision in the same cycle → `score` unchanged, `game_over`=1. Assert `reset` mid-PLAY → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the dodge-game rules engine.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   localparam int SCREEN_W     = 640;
   localparam int SCREEN_H     = 480;
   localparam int SPRITE_W_DEF = 32;
   localparam int SPRITE_H_DEF = 32;
   localparam int SCORE_MAX    = 99;

   localparam logic [9:0] LFSR_SEED = 10'h001;

   // True when a score value lands on a nonzero multiple of ten.
   function automatic logic is_decade(input logic [6:0] s);
      return (s != 7'd0) && ((s % 7'd10) == 7'd0);
   endfunction

endpackage

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1); maximal length, never zero.
module lfsr10
   import game_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic       reset,
   output logic [9:0] q
);

   logic [9:0] lfsr_q;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/game_state_controller.sv
// Play/over state machine, frame-based obstacle spawner, collision detect and scoring
// for the dodge game.
module game_state_controller
   import game_pkg::*;
#(
   parameter int SPRITE_W         = SPRITE_W_DEF,
   parameter int SPRITE_H         = SPRITE_H_DEF,
   parameter int SPAWN_FRAMES     = 90,
   parameter int MIN_SPAWN_FRAMES = 20,
   parameter int SPAWN_DEC        = 8,
   parameter int X_RANGE          = 608
)
(
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       vsync,
   input  logic       start_n,
   input  logic [9:0] player_x,
   input  logic [9:0] player_y,
   input  logic [9:0] obstacle_x,
   input  logic [9:0] obstacle_y,
   input  logic       obstacle_active,
   output logic       obstacle_trigger,
   output logic [9:0] obstacle_start_x,
   output logic [2:0] obstacle_step,
   output logic       playing,
   output logic       game_over,
   output logic [6:0] score,
   output logic [6:0] max_score
);

   localparam logic [10:0] SW11       = 11'(SPRITE_W);
   localparam logic [10:0] SH11       = 11'(SPRITE_H);
   localparam logic [15:0] PERIOD_RST = 16'(SPAWN_FRAMES);
   localparam logic [15:0] PERIOD_MIN = 16'(MIN_SPAWN_FRAMES);
   localparam logic [15:0] PERIOD_DEC = 16'(SPAWN_DEC);
   localparam logic [9:0]  XR10       = 10'(X_RANGE);
   localparam logic [6:0]  SMAX7      = 7'(SCORE_MAX);

   state_t      state_q;
   logic        start_s1_q, start_s2_q, start_s3_q;
   logic        vsync_q, act_q, pass_q;
   logic        trigger_q, playing_q, game_over_q;
   logic [9:0]  start_x_q;
   logic [2:0]  step_q;
   logic [6:0]  score_q, max_q;
   logic [15:0] timer_q, period_q;
   logic [9:0]  lfsr;

   logic        press, tick, overlap, coll, bump;
   logic [10:0] px, py, ox, oy;
   logic [9:0]  lfsr_fold;
   logic [6:0]  score_d;
   logic [15:0] period_d;
   logic [2:0]  step_d;

   lfsr10 u_lfsr (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .q        (lfsr)
   );

   assign press = start_s3_q & ~start_s2_q;
   assign tick  = vsync_q & ~vsync;

   // 11-bit operands so edge + sprite size cannot wrap near the screen edge.
   assign px = {1'b0, player_x};
   assign py = {1'b0, player_y};
   assign ox = {1'b0, obstacle_x};
   assign oy = {1'b0, obstacle_y};
   assign overlap = (px < ox + SW11) && (ox < px + SW11) &&
                    (py < oy + SH11) && (oy < py + SH11);
   assign coll = tick && (state_q == ST_PLAY) && obstacle_active && overlap;

   assign lfsr_fold = (lfsr >= XR10) ? lfsr - XR10 : lfsr;

   assign score_d  = (score_q < SMAX7) ? score_q + 7'd1 : score_q;
   assign bump     = (score_q < SMAX7) && is_decade(score_d);
   assign period_d = (period_q >= PERIOD_MIN + PERIOD_DEC) ? period_q - PERIOD_DEC : PERIOD_MIN;
   assign step_d   = (step_q == 3'd7) ? 3'd7 : step_q + 3'd1;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         start_s1_q  <= 1'b1;
         start_s2_q  <= 1'b1;
         start_s3_q  <= 1'b1;
         vsync_q     <= 1'b1;
         act_q       <= 1'b0;
         pass_q      <= 1'b0;
         trigger_q   <= 1'b0;
         playing_q   <= 1'b0;
         game_over_q <= 1'b0;
         start_x_q   <= 10'd0;
         step_q      <= 3'd1;
         score_q     <= 7'd0;
         max_q       <= 7'd0;
         timer_q     <= 16'd0;
         period_q    <= PERIOD_RST;
      end else begin
         start_s1_q <= start_n;
         start_s2_q <= start_s1_q;
         start_s3_q <= start_s2_q;
         vsync_q    <= vsync;
         act_q      <= obstacle_active;
         pass_q     <= act_q & ~obstacle_active & (state_q == ST_PLAY);
         trigger_q  <= 1'b0;

         case (state_q)
            ST_IDLE, ST_OVER: begin
               if (press) begin
                  state_q     <= ST_PLAY;
                  playing_q   <= 1'b1;
                  game_over_q <= 1'b0;
                  score_q     <= 7'd0;
                  timer_q     <= 16'd0;
                  period_q    <= PERIOD_RST;
                  step_q      <= 3'd1;
               end
            end
            ST_PLAY: begin
               // A collision outranks both a simultaneous pass and a due spawn.
               if (coll) begin
                  state_q     <= ST_OVER;
                  playing_q   <= 1'b0;
                  game_over_q <= 1'b1;
                  if (score_q > max_q) max_q <= score_q;
               end else begin
                  if (pass_q) begin
                     score_q <= score_d;
                     if (bump) begin
                        period_q <= period_d;
                        step_q   <= step_d;
                     end
                  end
                  if (tick) begin
                     if (timer_q == period_q - 16'd1) begin
                        timer_q   <= 16'd0;
                        trigger_q <= 1'b1;
                        start_x_q <= lfsr_fold;
                     end else begin
                        timer_q <= timer_q + 16'd1;
                     end
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign obstacle_trigger = trigger_q;
   assign obstacle_start_x = start_x_q;
   assign obstacle_step    = step_q;
   assign playing          = playing_q;
   assign game_over        = game_over_q;
   assign score            = score_q;
   assign max_score        = max_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller: scoreboard of expected values, checked
// with immediate assertions as the DUT produces them.
module tb_game_state_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync = 1'b1;
   logic       start_n = 1'b1;
   logic [9:0] player_x = 10'd100, player_y = 10'd400;
   logic [9:0] obstacle_x = 10'd500, obstacle_y = 10'd0;
   logic       obstacle_active = 1'b0;
   logic       obstacle_trigger;
   logic [9:0] obstacle_start_x;
   logic [2:0] obstacle_step;
   logic       playing, game_over;
   logic [6:0] score, max_score;

   int n_assert = 0;
   int n_fail   = 0;
   int exp_score = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   game_state_controller dut (
      .CLOCK_50         (clk),
      .reset            (rst),
      .vsync            (vsync),
      .start_n          (start_n),
      .player_x         (player_x),
      .player_y         (player_y),
      .obstacle_x       (obstacle_x),
      .obstacle_y       (obstacle_y),
      .obstacle_active  (obstacle_active),
      .obstacle_trigger (obstacle_trigger),
      .obstacle_start_x (obstacle_start_x),
      .obstacle_step    (obstacle_step),
      .playing          (playing),
      .game_over        (game_over),
      .score            (score),
      .max_score        (max_score)
   );

   // Reference LFSR; m_prev holds the value present before the most recent edge.
   logic [9:0] m_lfsr, m_prev;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_lfsr <= 10'h001;
         m_prev <= 10'h001;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
      end
   end

   function automatic logic [9:0] fold(input logic [9:0] v);
      return (v >= 10'd608) ? v - 10'd608 : v;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %0d with no expected entry", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.val) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
      $display("[%0t] %s observed=%0d expected=%0d", $time, e.tag, obs, e.val);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
      push(tag, e);
      pop_check(obs);
   endtask

   task automatic press();
      start_n = 1'b0;
      exp_score = 0;
      push("press_edge2_playing", 0);
      push("press_edge3_playing", 1);
      step(2);
      pop_check(32'(playing));
      step(1);
      pop_check(32'(playing));
      start_n = 1'b1;
      step(3);
   endtask

   task automatic pass_evt();
      obstacle_active = 1'b1;
      step(1);
      obstacle_active = 1'b0;
      exp_score = (exp_score < 99) ? exp_score + 1 : 99;
      push("score_after_pass", 32'(exp_score));
      step(2);
      pop_check(32'(score));
   endtask

   task automatic one_tick(output logic t1, output logic t2);
      vsync = 1'b0;
      step(1);
      t1 = obstacle_trigger;
      vsync = 1'b1;
      step(1);
      t2 = obstacle_trigger;
   endtask

   // Ticks until a trigger appears (n=-1 if none within limit); late flags a >1-cycle pulse.
   task automatic run_ticks(input int limit, output int n, output logic [9:0] sx,
                            output logic [9:0] esx, output logic late);
      n = -1; sx = '0; esx = '0; late = 1'b0;
      for (int i = 0; i < limit; i++) begin
         vsync = 1'b0;
         step(1);
         if (obstacle_trigger) begin
            n   = i + 1;
            sx  = obstacle_start_x;
            esx = fold(m_prev);
         end
         vsync = 1'b1;
         step(1);
         if (obstacle_trigger) late = 1'b1;
         if (n > 0) break;
      end
   endtask

   task automatic check_reset_outputs(input string sfx);
      chk({"rst_playing", sfx},   32'(playing), 0);
      chk({"rst_game_over", sfx}, 32'(game_over), 0);
      chk({"rst_trigger", sfx},   32'(obstacle_trigger), 0);
      chk({"rst_score", sfx},     32'(score), 0);
      chk({"rst_max_score", sfx}, 32'(max_score), 0);
      chk({"rst_start_x", sfx},   32'(obstacle_start_x), 0);
      chk({"rst_step", sfx},      32'(obstacle_step), 1);
   endtask

   task automatic collide_tick();
      obstacle_x = 10'd120; obstacle_y = 10'd380;
      obstacle_active = 1'b1;
      step(1);
      vsync = 1'b0;
      step(1);
      vsync = 1'b1;
      chk("collide_game_over", 32'(game_over), 1);
      chk("collide_playing", 32'(playing), 0);
      step(1);
      obstacle_active = 1'b0;
      obstacle_x = 10'd500; obstacle_y = 10'd0;
      step(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      logic [9:0] sx, esx;
      logic       late, t1, t2;

      // Reset state
      step(3);
      check_reset_outputs("");
      rst = 1'b0;
      step(2);

      // Start a game
      press();
      chk("play_score", 32'(score), 0);
      chk("play_step", 32'(obstacle_step), 1);

      // First spawn after exactly 90 ticks
      run_ticks(200, n, sx, esx, late);
      chk("spawn_ticks_90", 32'(n), 90);
      chk("spawn_one_cycle", 32'(late), 0);
      chk("spawn_x_in_range", 32'(sx <= 10'd607), 1);
      chk("spawn_x_lfsr", 32'(sx), 32'(esx));

      // Difficulty after 10 passes
      for (int i = 0; i < 10; i++) pass_evt();
      chk("diff10_step", 32'(obstacle_step), 2);
      run_ticks(200, n, sx, esx, late);
      chk("diff10_period_82", 32'(n), 82);
      chk("diff10_spawn_x", 32'(sx), 32'(esx));

      // Saturation after 100 passes total
      for (int i = 0; i < 90; i++) pass_evt();
      chk("sat_score_99", 32'(score), 99);
      chk("sat_step_7", 32'(obstacle_step), 7);
      run_ticks(200, n, sx, esx, late);
      chk("sat_period_20", 32'(n), 20);
      chk("sat_spawn_x", 32'(sx), 32'(esx));

      // Near miss, then collision on the same tick a spawn is due
      run_ticks(18, n, sx, esx, late);
      chk("pre_spawn_no_trigger", 32'(n), 32'(-1));
      obstacle_x = 10'd140; obstacle_y = 10'd380; obstacle_active = 1'b1;
      one_tick(t1, t2);
      chk("near_miss_game_over", 32'(game_over), 0);
      chk("near_miss_trigger", 32'(t1), 0);
      obstacle_x = 10'd120;
      one_tick(t1, t2);
      chk("coll_game_over", 32'(game_over), 1);
      chk("coll_trigger_suppressed", 32'(t1 | t2), 0);
      chk("coll_max_score", 32'(max_score), 99);
      chk("coll_score_held", 32'(score), 99);
      obstacle_active = 1'b0; obstacle_x = 10'd500; obstacle_y = 10'd0;
      step(3);

      // Restart keeps max_score, then asynchronous reset mid-game
      press();
      chk("restart_score", 32'(score), 0);
      chk("restart_max", 32'(max_score), 99);
      chk("restart_step", 32'(obstacle_step), 1);
      chk("restart_game_over", 32'(game_over), 0);
      for (int i = 0; i < 3; i++) pass_evt();
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("_async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(2);

      // Best score tracking across games
      press();
      for (int i = 0; i < 12; i++) pass_evt();
      collide_tick();
      chk("best12_max", 32'(max_score), 12);
      press();
      chk("best12_new_score", 32'(score), 0);
      chk("best12_kept", 32'(max_score), 12);
      for (int i = 0; i < 5; i++) pass_evt();
      collide_tick();
      chk("best12_after_5", 32'(max_score), 12);
      chk("score5_held", 32'(score), 5);

      // Pass and collision in the same cycle
      press();
      for (int i = 0; i < 2; i++) pass_evt();
      obstacle_x = 10'd120; obstacle_y = 10'd380;
      obstacle_active = 1'b1;
      step(1);
      obstacle_active = 1'b0;
      step(1);
      obstacle_active = 1'b1;
      vsync = 1'b0;
      step(1);
      vsync = 1'b1;
      chk("tie_game_over", 32'(game_over), 1);
      step(2);
      chk("tie_score_unchanged", 32'(score), 2);
      chk("tie_max_kept", 32'(max_score), 12);

      if (sb.size() != 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
